zprize_mul_acc_22: RTL
======================

Name: zprize_mul_acc_22

Overview:
- Downstream consumer of the cascaded-DSP wide multiplier.
- Takes the full-width product and the delay-matched metadata word from the multiplier, and accumulates sequences of products (sum-of-products) into a guard-extended accumulator.
- Emits one result per sequence into a small first-word-fall-through (FWFT) output FIFO with valid/ready.
- The multiplier cannot stall, so this block never backpressures its input; it reports almost-full and sticky overflow instead.

Parameters:
- W, 384, nominal operand width.
- W0, W, multiplier operand 0 width.
- W1, W, multiplier operand 1 width.
- M, 32, metadata width; must be ≥ 3.
- G, 8, accumulator guard bits above W0+W1.
- D, 4, output FIFO depth; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in0  in  W0+W1  product from the multiplier's out0.
- m_i  in  M  metadata from the multiplier's m_o:
  - bit0 = valid
  - bit1 = first
  - bit2 = last
  - [M-1:3] = tag
- acc_o  out  W0+W1+G  FIFO head: accumulated sum.
- acc_m_o  out  M  FIFO head: metadata of the sequence's last beat.
- acc_valid_o  out  1  FIFO not empty.
- acc_ready_i  in  1  consumer accepts the head.
- almost_full_o  out  1  FIFO count ≥ D-1.
- ovf_o  out  1  sticky: a result was dropped.

Behaviour:
- Reset (synchronous, active-high):
  - Accumulator and FIFO count reset to 0; read and write pointers reset to 0.
  - acc_valid_o, almost_full_o and ovf_o reset to 0.
  - acc_o and acc_m_o are 0 in the cycle after reset.
  - Reset mid-sequence discards the partial sum and all FIFO contents.
- A beat is a cycle with m_i[0]=1. Beats with m_i[0]=0 are ignored entirely; first and last bits are don't-care on those cycles.
- Width rule: the product is zero-extended to W0+W1+G bits. Sums wrap modulo 2^(W0+W1+G) with no flag.
- Next-sum computation:
  - sum = first ? ext(in0) : acc + ext(in0), computed combinationally from the registered acc.
- Update on a beat with last=0: acc ← sum.
- Update on a beat with last=1:
  - {sum, m_i} is pushed to the FIFO.
  - acc ← 0.
  - first=1 with last=1 yields a single-product result.
- A beat with first=0 directly after reset or after a last beat accumulates onto 0, so it behaves as first.
- Latency: last beat at cycle t → acc_valid_o=1 at t+1 if the FIFO was empty, with acc_o and acc_m_o valid in that cycle.
- FIFO rules:
  - Pop occurs when acc_valid_o & acc_ready_i.
  - Push and pop in the same cycle: count unchanged. When full this is legal and the push is not dropped.
  - Push when full with no pop: the result is dropped, FIFO unchanged, ovf_o ← 1. ovf_o clears only on reset.
  - Pop when empty: no effect.
  - Pointers wrap modulo D.
- acc_o and acc_m_o are don't-care while acc_valid_o=0, except directly after reset.
- almost_full_o is a registered function of the count; it updates the cycle after the count changes.
- No combinational path from acc_ready_i to any output other than through registered state.

Test Plan:
- Single-beat sequence: in0=6, m_i=0x0000_0107 (valid, first, last, tag=0x20) at t.
  - Required at t+1: acc_valid_o=1, acc_o=6, acc_m_o=0x0000_0107.
- Three-beat sequence with acc_ready_i=1: products 2^767, 2^767, 5 with first on beat 1 and last on beat 3.
  - Required: exactly one result, acc_o=2^768+5, i.e. guard bit 768 set.
- Wrap: G=1, two beats each with in0 = 2^768-1.
  - Required: acc_o = 2^769-2.
- Fill and overflow with acc_ready_i=0 and D=4:
  - Four single-beat results → almost_full_o=1 after the third, acc_valid_o=1.
  - Fifth result → dropped, ovf_o=1 sticky.
  - Then drain four entries in order with values 1,2,3,4; the fifth value (5) never appears.
- Full with simultaneous push and pop: FIFO full, acc_ready_i=1, and a last beat in the same cycle.
  - Required: ovf_o stays 0, count stays 4, new value emerges fourth.
- Reset mid-operation: two non-last beats (in0=9, 9), rst pulsed, then single beat in0=3 with first=0, last=1.
  - Required: acc_o=3, FIFO held no prior entries, ovf_o=0.
  - Interleaved invalid cycles (m_i[0]=0, in0=0xFFFF) anywhere in a sequence do not change the sum.

Source files
------------

// File: rtl/zprize_mul_acc_22.sv
// Sum-of-products accumulator behind the cascaded-DSP multiplier.
// Results leave through a small FWFT FIFO; the input is never stalled.
module zprize_mul_acc_22 #(
    parameter int W  = 384,
    parameter int W0 = W,
    parameter int W1 = W,
    parameter int M  = 32,
    parameter int G  = 8,
    parameter int D  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W0+W1-1:0]      in0,
    input  logic [M-1:0]          m_i,
    output logic [W0+W1+G-1:0]    acc_o,
    output logic [M-1:0]          acc_m_o,
    output logic                  acc_valid_o,
    input  logic                  acc_ready_i,
    output logic                  almost_full_o,
    output logic                  ovf_o
);

    localparam int PW  = W0 + W1;
    localparam int AW  = PW + G;
    localparam int PTW = $clog2(D);
    localparam int CW  = PTW + 1;

    logic [AW-1:0]  acc_q, acc_d;
    logic [AW-1:0]  ext;
    logic [AW-1:0]  sum;
    logic           beat, first, last;

    logic [AW-1:0]  mem_acc_q [D];
    logic [M-1:0]   mem_m_q   [D];
    logic [PTW-1:0] rd_q, rd_d;
    logic [PTW-1:0] wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           af_q, af_d;
    logic           ovf_q, ovf_d;

    logic           push_req, push, pop, full, drop;

    assign beat  = m_i[0];
    assign first = m_i[1];
    assign last  = m_i[2];
    assign ext   = {{G{1'b0}}, in0};

    // A cleared accumulator makes a missing first bit harmless.
    always_comb begin
        sum   = first ? ext : acc_q + ext;
        acc_d = acc_q;
        if (beat) begin
            acc_d = last ? '0 : sum;
        end
    end

    assign full     = (cnt_q == CW'(D));
    assign pop      = (cnt_q != '0) & acc_ready_i;
    assign push_req = beat & last;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q | drop;
        af_d  = (cnt_q >= CW'(D - 1));
        if (pop) begin
            rd_d = rd_q + PTW'(1);
        end
        if (push) begin
            wr_d = wr_q + PTW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            af_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            af_q  <= af_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_acc_q[wr_q] <= sum;
            mem_m_q[wr_q]   <= m_i;
        end
    end

    // Head is masked while empty so stale storage never shows after reset.
    assign acc_valid_o   = (cnt_q != '0);
    assign acc_o         = acc_valid_o ? mem_acc_q[rd_q] : '0;
    assign acc_m_o       = acc_valid_o ? mem_m_q[rd_q] : '0;
    assign almost_full_o = af_q;
    assign ovf_o         = ovf_q;

endmodule
